// File: rtl/fetch_unit_if.sv
// Fetch-unit bus bundle: program-memory address/data and the instruction
// valid/ready channel toward decode, plus the jump/halt controls.
//   master : fetch_unit side (drives mem_addr, instr, instr_addr, instr_valid)
//   slave  : environment side (drives mem_data, instr_ready, jump_en, jump_addr, halt)
interface fetch_unit_if #(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DATA_WIDTH = 8
);
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_data;
  logic [DATA_WIDTH-1:0] instr;
  logic [ADDR_WIDTH-1:0] instr_addr;
  logic                  instr_valid;
  logic                  instr_ready;
  logic                  jump_en;
  logic [ADDR_WIDTH-1:0] jump_addr;
  logic                  halt;

  modport master (
    output mem_addr, instr, instr_addr, instr_valid,
    input  mem_data, instr_ready, jump_en, jump_addr, halt
  );

  modport slave (
    input  mem_addr, instr, instr_addr, instr_valid,
    output mem_data, instr_ready, jump_en, jump_addr, halt
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage. Presents the PC to an async-read program memory,
// waits WAIT_CYCLES unhalted cycles, latches the returned byte and offers it
// to decode with a valid/ready handshake. All outputs are registered.
// Ports:
//   clk  : rising-edge clock
//   rst  : asynchronous, active-high reset
//   bus  : fetch_unit_if.master (mem_addr/mem_data, instr/instr_addr/
//          instr_valid/instr_ready, jump_en/jump_addr, halt)
module fetch_unit #(
  parameter int unsigned ADDR_WIDTH  = 8,
  parameter int unsigned DATA_WIDTH  = 8,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic         clk,
  input  logic         rst,
  fetch_unit_if.master bus
);

  localparam int unsigned CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_CYCLES - 1);

  typedef enum logic {
    S_WAIT,
    S_HOLD
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [CNT_W-1:0]      wait_cnt_q, wait_cnt_d;
  logic [DATA_WIDTH-1:0] instr_q, instr_d;
  logic [ADDR_WIDTH-1:0] instr_addr_q, instr_addr_d;
  logic                  valid_q, valid_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_WAIT;
      pc_q         <= RESET_PC;
      wait_cnt_q   <= '0;
      instr_q      <= '0;
      instr_addr_q <= '0;
      valid_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      wait_cnt_q   <= wait_cnt_d;
      instr_q      <= instr_d;
      instr_addr_q <= instr_addr_d;
      valid_q      <= valid_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    wait_cnt_d   = wait_cnt_q;
    instr_d      = instr_q;
    instr_addr_d = instr_addr_q;
    valid_d      = valid_q;

    if (bus.jump_en) begin
      // Jump overrides everything: a held instruction is dropped (or counts
      // as delivered if ready was also high) and a pending capture is lost.
      pc_d       = bus.jump_addr;
      wait_cnt_d = '0;
      valid_d    = 1'b0;
      state_d    = S_WAIT;
    end else begin
      unique case (state_q)
        S_WAIT: begin
          if (!bus.halt) begin
            if (wait_cnt_q == CNT_LAST) begin
              instr_d      = bus.mem_data;
              instr_addr_d = pc_q;
              valid_d      = 1'b1;
              pc_d         = pc_q + ADDR_WIDTH'(1);
              wait_cnt_d   = '0;
              state_d      = S_HOLD;
            end else begin
              wait_cnt_d = wait_cnt_q + CNT_W'(1);
            end
          end
        end
        S_HOLD: begin
          // halt is deliberately not looked at here; it only stalls WAIT.
          if (bus.instr_ready) begin
            valid_d = 1'b0;
            state_d = S_WAIT;
          end
        end
        default: state_d = S_WAIT;
      endcase
    end
  end

  assign bus.mem_addr    = pc_q;
  assign bus.instr       = instr_q;
  assign bus.instr_addr  = instr_addr_q;
  assign bus.instr_valid = valid_q;

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       ready, jen, halt;
  logic [7:0] jaddr;
  logic [7:0] mem [256];

  fetch_unit_if #(.ADDR_WIDTH(8), .DATA_WIDTH(8)) b1 ();
  fetch_unit_if #(.ADDR_WIDTH(8), .DATA_WIDTH(8)) b3 ();

  assign b1.mem_data    = mem[b1.mem_addr];
  assign b1.instr_ready = ready;
  assign b1.jump_en     = jen;
  assign b1.jump_addr   = jaddr;
  assign b1.halt        = halt;
  assign b3.mem_data    = mem[b3.mem_addr];
  assign b3.instr_ready = ready;
  assign b3.jump_en     = jen;
  assign b3.jump_addr   = jaddr;
  assign b3.halt        = halt;

  fetch_unit #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .RESET_PC(8'h00), .WAIT_CYCLES(1))
    dut1 (.clk(clk), .rst(rst), .bus(b1));
  fetch_unit #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .RESET_PC(8'h00), .WAIT_CYCLES(3))
    dut3 (.clk(clk), .rst(rst), .bus(b3));

  // Reference model: one record per DUT; "settled" counts unhalted cycles the
  // current address has been presented.
  typedef struct {
    int pc;
    int settled;
    bit valid;
    int instr;
    int iaddr;
  } mdl_t;

  mdl_t m [2];
  int   wc [2] = '{1, 3};
  int   total = 0;
  int   bad   = 0;

  function automatic void mreset(int k);
    m[k].pc = 0; m[k].settled = 0; m[k].valid = 0; m[k].instr = 0; m[k].iaddr = 0;
  endfunction

  function automatic void medge(int k);
    if (jen) begin
      m[k].pc = int'(jaddr);
      m[k].settled = 0;
      m[k].valid = 0;
    end else if (!m[k].valid) begin
      if (!halt) begin
        if (m[k].settled + 1 == wc[k]) begin
          m[k].instr = int'(mem[m[k].pc]);
          m[k].iaddr = m[k].pc;
          m[k].valid = 1;
          m[k].pc = (m[k].pc + 1) % 256;
          m[k].settled = 0;
        end else begin
          m[k].settled++;
        end
      end
    end else if (ready) begin
      m[k].valid = 0;
    end
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all();
    chk("d1.mem_addr",   32'(b1.mem_addr),    m[0].pc);
    chk("d1.valid",      32'(b1.instr_valid), 32'(m[0].valid));
    chk("d1.instr",      32'(b1.instr),       m[0].instr);
    chk("d1.instr_addr", 32'(b1.instr_addr),  m[0].iaddr);
    chk("d3.mem_addr",   32'(b3.mem_addr),    m[1].pc);
    chk("d3.valid",      32'(b3.instr_valid), 32'(m[1].valid));
    chk("d3.instr",      32'(b3.instr),       m[1].instr);
    chk("d3.instr_addr", 32'(b3.instr_addr),  m[1].iaddr);
  endtask

  task automatic step();
    @(posedge clk);
    medge(0);
    medge(1);
    #1;
    chk_all();
  endtask

  // Asynchronous reset pulse placed between clock edges.
  task automatic pulse_rst();
    #2 rst = 1'b1;
    #1;
    mreset(0);
    mreset(1);
    chk_all();
    #2 rst = 1'b0;
  endtask

  initial begin
    ready = 1'b0; jen = 1'b0; halt = 1'b0; jaddr = 8'h00;
    for (int unsigned i = 0; i < 256; i++) mem[i] = 8'($urandom);
    mem[0] = 8'h10; mem[1] = 8'h11; mem[2] = 8'h12;
    mreset(0);
    mreset(1);
    #1;
    chk_all();
    #1 rst = 1'b0;

    // In-order fetch with ready tied high.
    ready = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      step();
      if (i % 2 == 1) begin
        chk("t1.valid", 32'(b1.instr_valid), 1);
        chk("t1.instr", 32'(b1.instr), 32'h10 + (i - 1) / 2);
        chk("t1.addr",  32'(b1.instr_addr), (i - 1) / 2);
      end else begin
        chk("t1.valid_gap", 32'(b1.instr_valid), 0);
      end
      if (i == 3) chk("t1.d3_first", 32'(b3.instr), 32'h10);
    end

    // Backpressure holds the first instruction.
    pulse_rst();
    ready = 1'b0;
    repeat (7) step();
    chk("t2.instr", 32'(b1.instr), 32'h10);
    chk("t2.addr",  32'(b1.instr_addr), 0);
    chk("t2.pc",    32'(b1.mem_addr), 1);
    chk("t2.valid", 32'(b1.instr_valid), 1);
    ready = 1'b1;
    step();
    chk("t2.handshake", 32'(b1.instr_valid), 0);

    // Jump while holding with ready low flushes the held byte.
    ready = 1'b0;
    repeat (4) step();
    jen = 1'b1; jaddr = 8'h80;
    step();
    chk("t3.flush", 32'(b1.instr_valid), 0);
    chk("t3.pc",    32'(b1.mem_addr), 32'h80);
    jen = 1'b0;
    step();
    chk("t3.addr",  32'(b1.instr_addr), 32'h80);
    chk("t3.next",  32'(b1.mem_addr), 32'h81);
    ready = 1'b1;
    repeat (6) step();

    // PC wrap at the top of the address space.
    jen = 1'b1; jaddr = 8'hFF;
    step();
    jen = 1'b0;
    step();
    chk("t4.addr_ff", 32'(b1.instr_addr), 32'hFF);
    chk("t4.wrap_pc", 32'(b1.mem_addr), 0);
    repeat (2) step();
    chk("t4.addr_00", 32'(b1.instr_addr), 0);
    repeat (6) step();

    // Halt stalls WAIT for both wait settings.
    halt = 1'b1;
    repeat (4) step();
    halt = 1'b0;
    repeat (8) step();

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      ready = ($urandom_range(0, 9) < 7);
      jen   = ($urandom_range(0, 19) == 0);
      halt  = ($urandom_range(0, 6) == 0);
      jaddr = 8'($urandom);
      step();
      if ($urandom_range(0, 99) == 0) pulse_rst();
    end
    jen = 1'b0; halt = 1'b0;

    // Reset while an instruction is held.
    pulse_rst();
    ready = 1'b0;
    repeat (4) step();
    chk("t6.held", 32'(b1.instr_valid), 1);
    pulse_rst();
    chk("t6.drop1", 32'(b1.instr_valid), 0);
    chk("t6.drop3", 32'(b3.instr_valid), 0);
    ready = 1'b1;
    step();
    chk("t6.first_addr", 32'(b1.instr_addr), 0);
    repeat (4) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
